// File: rtl/cdc_hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_hs_pkg
//  Description : Shared types and constants for the 4-phase req/ack CDC
//                handshake transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_hs_pkg;

    // Transmitter handshake phases
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } tx_state_e;

    // Width of the completed-transfer counter
    localparam int XFER_CNT_W = 16;

endpackage : cdc_hs_pkg
`default_nettype wire

// File: rtl/cdc_hs_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rstn_if
//  Description : Clock and asynchronous active-low reset bundle for the
//                transmitter domain.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_rstn_if;
    logic clk_i;
    logic rstn_i;

    // Driver side (clock/reset generator)
    modport master (output clk_i, output rstn_i);
    // Consumer side (clocked logic)
    modport slave  (input  clk_i, input  rstn_i);
endinterface : clk_rstn_if
`default_nettype wire

// File: rtl/cdc_hs_tx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sync_nff
//  Description : N-stage single-bit synchronizer, reset to 0, used to bring
//                the asynchronous ack into the local clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_nff #(
    parameter int N = 2
) (
    clk_rstn_if.slave interf,
    input  logic      d_i,
    output logic      q_o
);

    logic [N-1:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge interf.clk_i or negedge interf.rstn_i) begin
        if (!interf.rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule : sync_nff
`default_nettype wire

// File: rtl/cdc_hs_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_hs_tx
//  Description : Source-domain transmitter of a 4-phase req/ack CDC
//                handshake. Accepts a word over valid/ready, holds it on
//                data_ao, raises data_av_o and waits for the synchronised
//                remote ack to rise and then fall.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    clk_rstn_if.slave               interf,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    clr_i,
    input  logic                    ack_ai,
    output logic                    data_av_o,
    output logic [DATA_W-1:0]       data_ao,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic [XFER_CNT_W-1:0]   xfer_cnt_o
);

    // Wide enough to hold TIMEOUT_CYC itself so the counter can saturate there
    localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    tx_state_e                 state_q;
    logic [DATA_W-1:0]         data_q;
    logic                      av_q;
    logic                      to_q;
    logic [XFER_CNT_W-1:0]     cnt_q;
    logic [TO_W-1:0]           to_cnt_q;
    logic                      ack_s;

    logic                      waiting_d;
    logic                      to_inc_d;
    logic [TO_W-1:0]           to_cnt_d;
    logic                      to_set_d;

    sync_nff #(.N(SYNC_STAGES)) u_ack_sync (
        .interf (interf),
        .d_i    (ack_ai),
        .q_o    (ack_s)
    );

    // Still waiting on the remote in either wait phase (no transition this edge)
    assign waiting_d = ((state_q == REQ) && !ack_s) || ((state_q == ACK_LOW) && ack_s);
    assign to_inc_d  = waiting_d && (to_cnt_q != TO_MAX);
    assign to_cnt_d  = to_cnt_q + TO_W'(1);
    assign to_set_d  = (TIMEOUT_CYC != 0) && to_inc_d && (to_cnt_d == TO_MAX);

    // Handshake FSM with data hold, timeout tracking and transfer counting
    always_ff @(posedge interf.clk_i or negedge interf.rstn_i) begin
        if (!interf.rstn_i) begin
            state_q  <= IDLE;
            data_q   <= '0;
            av_q     <= 1'b0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && !ack_s) begin
                        data_q   <= data_i;
                        av_q     <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        av_q     <= 1'b0;
                        to_cnt_q <= '0;
                        state_q  <= ACK_LOW;
                    end else if (to_inc_d) begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                ACK_LOW: begin
                    if (!ack_s) begin
                        cnt_q    <= cnt_q + XFER_CNT_W'(1);
                        to_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else if (to_inc_d) begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Sticky flag: a set on the same edge as a clear takes priority
            if (to_set_d) begin
                to_q <= 1'b1;
            end else if (clr_i) begin
                to_q <= 1'b0;
            end
        end
    end

    // Refuse new words while the remote still holds ack high
    assign ready_o    = (state_q == IDLE) && !ack_s;
    assign busy_o     = (state_q != IDLE);
    assign data_av_o  = av_q;
    assign data_ao    = data_q;
    assign timeout_o  = to_q;
    assign xfer_cnt_o = cnt_q;

endmodule : cdc_hs_tx
`default_nettype wire
